// File: rtl/ps2_cmd_sequencer_pkg.sv
// Constants and state types shared by the PS/2 host command sequencer and its timer.
package ps2_cmd_sequencer_pkg;

  localparam logic [7:0] CmdReset   = 8'hFF;
  localparam logic [7:0] CmdSetLed  = 8'hED;
  localparam logic [7:0] RspAck     = 8'hFA;
  localparam logic [7:0] RspResend  = 8'hFE;
  localparam logic [7:0] RspBatOk   = 8'hAA;
  localparam logic [7:0] RspBatFail = 8'hFC;

  typedef enum logic [3:0] {
    StRstTx,
    StRstDone,
    StRstAck,
    StWaitBat,
    StIdle,
    StLedCmdTx,
    StLedCmdDone,
    StLedCmdAck,
    StLedArgTx,
    StLedArgDone,
    StLedArgAck,
    StError
  } state_e;

  // Position of a state inside the generic send/complete/acknowledge byte cycle.
  typedef enum logic [1:0] {
    PhTx,
    PhDone,
    PhAck,
    PhOther
  } phase_e;

  function automatic phase_e state_phase(state_e st);
    case (st)
      StRstTx, StLedCmdTx, StLedArgTx:       state_phase = PhTx;
      StRstDone, StLedCmdDone, StLedArgDone: state_phase = PhDone;
      StRstAck, StLedCmdAck, StLedArgAck:    state_phase = PhAck;
      default:                               state_phase = PhOther;
    endcase
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_cmd_sequencer_if.sv
// Byte-level link between the command sequencer and the PS/2 writer/reader pair.
interface ps2_cmd_sequencer_if;

  logic       tx_send;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_busy;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (
    output tx_send,
    output tx_data,
    input  tx_busy,
    input  rx_busy,
    input  rx_valid,
    input  rx_data
  );

  modport slave (
    input  tx_send,
    input  tx_data,
    output tx_busy,
    output rx_busy,
    output rx_valid,
    output rx_data
  );

endinterface

// File: rtl/ps2_cmd_sequencer_timeout.sv
// Saturating cycle counter shared by all waiting states; hit_o flags that limit_i was reached.
module ps2_cmd_sequencer_timeout #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic             hit_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = en_i && (cnt_q >= limit_i);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command sequencer: device reset/BAT handshake, LED updates with ACK/resend
// handling and timeouts, and forwarding of unsolicited device bytes while idle.
module ps2_cmd_sequencer
  import ps2_cmd_sequencer_pkg::*;
#(
  parameter int unsigned AckToCyc = 2_000_000,
  parameter int unsigned BatToCyc = 100_000_000,
  parameter int unsigned TxDoneTo = 1_500_000,
  parameter int unsigned MaxRetry = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  ps2_cmd_sequencer_if.master        bus_io,
  input  logic                       led_req_i,
  input  logic [2:0]                 led_val_i,
  output logic                       scan_valid_o,
  output logic [7:0]                 scan_data_o,
  output logic                       ready_o,
  output logic                       led_pend_o,
  output logic                       error_o
);

  localparam int unsigned MaxLimit = max_u(max_u(AckToCyc, BatToCyc), TxDoneTo);
  localparam int unsigned TimerW   = $clog2(MaxLimit + 1);
  localparam int unsigned RetryW   = (MaxRetry > 0) ? $clog2(MaxRetry + 1) : 1;

  state_e              state_q, state_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic                seen_busy_q, seen_busy_d;
  logic                tx_send_q, tx_send_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                scan_valid_q, scan_valid_d;
  logic [7:0]          scan_data_q, scan_data_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic                led_pend_q, led_pend_d;
  logic                led_new_q, led_new_d;
  logic [2:0]          led_val_q, led_val_d;

  phase_e              phase;
  state_e              st_tx, st_done, st_ack, st_ok;
  logic [7:0]          cur_byte;
  logic                retry_bump;
  logic                rx_ack, rx_resend;

  logic                tmr_clr, tmr_en, tmr_hit;
  logic [TimerW-1:0]   tmr_limit;

  assign rx_ack    = bus_io.rx_valid && (bus_io.rx_data == RspAck);
  assign rx_resend = bus_io.rx_valid && (bus_io.rx_data == RspResend);

  // Which byte cycle the current state belongs to, and where that cycle leads.
  always_comb begin
    phase    = state_phase(state_q);
    st_tx    = StRstTx;
    st_done  = StRstDone;
    st_ack   = StRstAck;
    st_ok    = StWaitBat;
    cur_byte = CmdReset;
    case (state_q)
      StLedCmdTx, StLedCmdDone, StLedCmdAck: begin
        st_tx    = StLedCmdTx;
        st_done  = StLedCmdDone;
        st_ack   = StLedCmdAck;
        st_ok    = StLedArgTx;
        cur_byte = CmdSetLed;
      end
      StLedArgTx, StLedArgDone, StLedArgAck: begin
        st_tx    = StLedArgTx;
        st_done  = StLedArgDone;
        st_ack   = StLedArgAck;
        st_ok    = StIdle;
        cur_byte = {5'b0, led_val_q};
      end
      default: ;
    endcase
  end

  always_comb begin
    tmr_en    = 1'b0;
    tmr_limit = '1;
    unique case (phase)
      PhDone: begin
        tmr_en    = 1'b1;
        tmr_limit = TimerW'(TxDoneTo);
      end
      PhAck: begin
        tmr_en    = 1'b1;
        tmr_limit = TimerW'(AckToCyc);
      end
      PhTx: ;
      PhOther: begin
        if (state_q == StWaitBat) begin
          tmr_en    = 1'b1;
          tmr_limit = TimerW'(BatToCyc);
        end
      end
    endcase
  end

  assign tmr_clr = (state_d != state_q);

  ps2_cmd_sequencer_timeout #(
    .Width (TimerW)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .hit_o   (tmr_hit)
  );

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    seen_busy_d  = seen_busy_q;
    tx_send_d    = 1'b0;
    tx_data_d    = tx_data_q;
    scan_valid_d = 1'b0;
    scan_data_d  = scan_data_q;
    retry_bump   = 1'b0;

    unique case (phase)
      PhTx: begin
        if (!bus_io.tx_busy && !bus_io.rx_busy) begin
          tx_send_d   = 1'b1;
          tx_data_d   = cur_byte;
          seen_busy_d = 1'b0;
          state_d     = st_done;
        end
      end
      PhDone: begin
        if (bus_io.tx_busy) begin
          seen_busy_d = 1'b1;
        end
        if (seen_busy_q && !bus_io.tx_busy) begin
          state_d = st_ack;
        end else if (tmr_hit) begin
          retry_bump = 1'b1;
        end
      end
      PhAck: begin
        if (rx_ack) begin
          retry_d = '0;
          state_d = st_ok;
        end else if (rx_resend || tmr_hit) begin
          retry_bump = 1'b1;
        end
      end
      PhOther: begin
        case (state_q)
          StWaitBat: begin
            if (bus_io.rx_valid && (bus_io.rx_data == RspBatOk)) begin
              state_d = StIdle;
            end else if ((bus_io.rx_valid && (bus_io.rx_data == RspBatFail)) || tmr_hit) begin
              state_d = StError;
            end
          end
          StIdle: begin
            if (bus_io.rx_valid) begin
              scan_valid_d = 1'b1;
              scan_data_d  = bus_io.rx_data;
            end
            // A BAT pass while idle means the device was hot-plugged.
            if (bus_io.rx_valid && (bus_io.rx_data == RspBatOk)) begin
              state_d = StRstTx;
            end else if (led_pend_q) begin
              state_d = StLedCmdTx;
            end
          end
          default: ;
        endcase
      end
    endcase

    if (retry_bump) begin
      if (retry_q < RetryW'(MaxRetry)) begin
        retry_d = retry_q + 1'b1;
        state_d = st_tx;
      end else begin
        state_d = StError;
      end
    end
  end

  // led_new tracks requests that arrived after the current SETLED started, so they get
  // another pass instead of being lost when the argument completes.
  always_comb begin
    led_pend_d = led_pend_q;
    led_new_d  = led_new_q;
    led_val_d  = led_val_q;
    if ((state_q == StLedCmdTx) && tx_send_d) begin
      led_new_d = 1'b0;
    end
    if ((state_q == StLedArgAck) && (state_d == StIdle)) begin
      led_pend_d = led_new_q;
    end
    if (led_req_i && (state_q != StError)) begin
      led_pend_d = 1'b1;
      led_new_d  = 1'b1;
      led_val_d  = led_val_i;
    end
  end

  assign ready_d = (state_d == StIdle);
  assign error_d = error_q || (state_d == StError);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StRstTx;
      retry_q      <= '0;
      seen_busy_q  <= 1'b0;
      tx_send_q    <= 1'b0;
      tx_data_q    <= '0;
      scan_valid_q <= 1'b0;
      scan_data_q  <= '0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
      led_pend_q   <= 1'b0;
      led_new_q    <= 1'b0;
      led_val_q    <= '0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      seen_busy_q  <= seen_busy_d;
      tx_send_q    <= tx_send_d;
      tx_data_q    <= tx_data_d;
      scan_valid_q <= scan_valid_d;
      scan_data_q  <= scan_data_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
      led_pend_q   <= led_pend_d;
      led_new_q    <= led_new_d;
      led_val_q    <= led_val_d;
    end
  end

  assign bus_io.tx_send = tx_send_q;
  assign bus_io.tx_data = tx_data_q;
  assign scan_valid_o   = scan_valid_q;
  assign scan_data_o    = scan_data_q;
  assign ready_o        = ready_q;
  assign led_pend_o     = led_pend_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed/randomised bench for ps2_cmd_sequencer with a byte-writer model and
// expected-byte/scan queues derived from the command protocol.
module tb_ps2_cmd_sequencer;

  localparam int unsigned AckTo  = 40;
  localparam int unsigned BatTo  = 300;
  localparam int unsigned DoneTo = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       led_req = 1'b0;
  logic [2:0] led_val = '0;
  logic       scan_valid, ready, led_pend, error;
  logic [7:0] scan_data;

  ps2_cmd_sequencer_if bus ();

  ps2_cmd_sequencer #(
    .AckToCyc (AckTo),
    .BatToCyc (BatTo),
    .TxDoneTo (DoneTo),
    .MaxRetry (3)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus_io       (bus),
    .led_req_i    (led_req),
    .led_val_i    (led_val),
    .scan_valid_o (scan_valid),
    .scan_data_o  (scan_data),
    .ready_o      (ready),
    .led_pend_o   (led_pend),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] sent_q[$];
  int         sent_t[$];
  logic [7:0] scan_got[$];
  logic [7:0] scan_exp[$];
  logic [2:0] m_led;

  bit         wr_active = 0;
  int         wr_wait, wr_len;
  logic [7:0] wr_byte;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Writer model: busy rises 1-3 cycles after a send and lasts 2-5 cycles.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      wr_active   = 0;
      bus.tx_busy = 1'b0;
    end else if (bus.tx_send) begin
      chk("send_gate", {31'b0, bus.rx_busy | bus.tx_busy}, 0);
      sent_q.push_back(bus.tx_data);
      sent_t.push_back(cyc);
      wr_byte   = bus.tx_data;
      wr_active = 1;
      wr_wait   = $urandom_range(1, 3);
      wr_len    = $urandom_range(2, 5);
    end else if (wr_active) begin
      if (wr_wait > 0) begin
        wr_wait--;
        if (wr_wait == 0) bus.tx_busy = 1'b1;
      end else begin
        chk("tx_data_stable", {24'b0, bus.tx_data}, {24'b0, wr_byte});
        wr_len--;
        if (wr_len == 0) begin
          bus.tx_busy = 1'b0;
          wr_active   = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (scan_valid) scan_got.push_back(scan_data);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_led(input logic [2:0] v);
    led_req = 1'b1;
    led_val = v;
    m_led   = v;
    @(negedge clk);
    led_req = 1'b0;
  endtask

  task automatic expect_send(input string tag, input logic [7:0] exp, output int t);
    int k;
    t = 0;
    for (k = 0; k < 200 && sent_q.size() == 0; k++) @(negedge clk);
    if (sent_q.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      t = sent_t.pop_front();
      chk(tag, {24'b0, sent_q.pop_front()}, {24'b0, exp});
      for (k = 0; k < 50 && wr_active; k++) @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_init(input int n_resend);
    int t;
    for (int i = 0; i <= n_resend; i++) begin
      expect_send("init_ff", 8'hFF, t);
      rx((i < n_resend) ? 8'hFE : 8'hFA);
    end
    rx(8'hAA);
    for (int k = 0; k < 2 && !ready; k++) @(negedge clk);
    chk("init_ready", {31'b0, ready}, 1);
    chk("init_error", {31'b0, error}, 0);
  endtask

  task automatic expect_led_pair(input string tag);
    int t;
    expect_send({tag, "_cmd"}, 8'hED, t);
    rx(8'hFA);
    expect_send({tag, "_arg"}, {5'b0, m_led}, t);
    rx(8'hFA);
  endtask

  task automatic check_scans(input string tag);
    chk({tag, "_count"}, scan_got.size(), scan_exp.size());
    while (scan_got.size() > 0 && scan_exp.size() > 0)
      chk(tag, {24'b0, scan_got.pop_front()}, {24'b0, scan_exp.pop_front()});
    scan_got.delete();
    scan_exp.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick(3);
    sent_q.delete();
    sent_t.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int t0, t1, gap;
    logic [7:0] b;
    logic [2:0] v;
    int times[4];

    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.rx_busy  = 1'b0;
    bus.tx_busy  = 1'b0;

    // Reset state.
    tick(3);
    chk("rst_tx_send", {31'b0, bus.tx_send}, 0);
    chk("rst_tx_data", {24'b0, bus.tx_data}, 0);
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_led_pend", {31'b0, led_pend}, 0);
    chk("rst_error", {31'b0, error}, 0);
    chk("rst_scan_valid", {31'b0, scan_valid}, 0);
    rst_n = 1'b1;

    // Plain initialisation: FF sent exactly once.
    do_init(0);
    tick(20);
    chk("init_single_send", sent_q.size(), 0);

    // Unsolicited bytes in IDLE are forwarded in order.
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hAA) b = 8'h55;
      scan_exp.push_back(b);
      rx(b);
      tick($urandom_range(0, 2));
    end
    tick(2);
    check_scans("scan_rand");

    // LED update with 101, then random values.
    pulse_led(3'b101);
    expect_led_pair("led_101");
    tick(2);
    chk("led_pend_clear", {31'b0, led_pend}, 0);
    chk("led_ready", {31'b0, ready}, 1);
    for (int i = 0; i < 3; i++) begin
      v = 3'($urandom_range(0, 7));
      pulse_led(v);
      expect_led_pair("led_rand");
      tick(2);
      chk("led_rand_pend", {31'b0, led_pend}, 0);
    end

    // Merge: new request during LEDCMD_ACK yields a second pair with the latest value.
    pulse_led(3'b101);
    expect_send("merge_cmd1", 8'hED, t0);
    pulse_led(3'b010);
    rx(8'hFA);
    expect_send("merge_arg1", 8'h02, t0);
    rx(8'hFA);
    expect_led_pair("merge_2");
    tick(2);
    chk("merge_pend", {31'b0, led_pend}, 0);
    scan_exp.push_back(8'h1C);
    rx(8'h1C);
    tick(2);
    check_scans("merge_scan");

    // Simultaneous rx byte and LED request in IDLE.
    led_req = 1'b1;
    led_val = 3'b011;
    m_led   = 3'b011;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h33;
    scan_exp.push_back(8'h33);
    @(negedge clk);
    led_req = 1'b0;
    bus.rx_valid = 1'b0;
    expect_led_pair("simul");
    tick(2);
    check_scans("simul_scan");

    // Reader busy holds off the transmit.
    bus.rx_busy = 1'b1;
    pulse_led(3'b110);
    tick(15);
    chk("rxbusy_hold", sent_q.size(), 0);
    bus.rx_busy = 1'b0;
    expect_led_pair("rxbusy");
    tick(2);

    // Hot-plug BAT in IDLE: forwarded, then re-init with two resends.
    scan_exp.push_back(8'hAA);
    rx(8'hAA);
    tick(1);
    check_scans("hotplug_scan");
    do_init(2);

    // Reset while the LED argument byte is being written.
    pulse_led(3'b001);
    expect_send("rstmid_cmd", 8'hED, t0);
    rx(8'hFA);
    for (int k = 0; k < 50 && sent_q.size() == 0; k++) @(negedge clk);
    chk("rstmid_arg_seen", sent_q.size(), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx_send", {31'b0, bus.tx_send}, 0);
    chk("rstmid_ready", {31'b0, ready}, 0);
    chk("rstmid_led_pend", {31'b0, led_pend}, 0);
    chk("rstmid_error", {31'b0, error}, 0);
    tick(3);
    sent_q.delete();
    sent_t.delete();
    rst_n = 1'b1;
    do_init(0);
    tick(20);
    chk("rstmid_no_led", sent_q.size(), 0);

    // BAT failure code goes to ERROR.
    apply_reset();
    expect_send("batfail_ff", 8'hFF, t0);
    rx(8'hFA);
    rx(8'hFC);
    tick(2);
    chk("batfail_error", {31'b0, error}, 1);
    chk("batfail_ready", {31'b0, ready}, 0);

    // No reply at all: four FF sends spaced by the ACK timeout, then ERROR for good.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      expect_send("to_ff", 8'hFF, t1);
      times[i] = t1;
    end
    for (int i = 1; i < 4; i++) begin
      gap = times[i] - times[i-1];
      chk("to_gap", {31'b0, (gap >= int'(AckTo)) && (gap <= int'(AckTo) + 20)}, 1);
    end
    tick(AckTo + 20);
    chk("to_error", {31'b0, error}, 1);
    chk("to_ready", {31'b0, ready}, 0);
    pulse_led(3'b111);
    rx(8'hAA);
    tick(3 * AckTo);
    chk("to_no_more_sends", sent_q.size(), 0);
    chk("to_error_sticky", {31'b0, error}, 1);
    chk("to_ready_low", {31'b0, ready}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
